// File: rtl/booth_mul_sequencer.sv
// rtl/booth_mul_sequencer.sv - issue/collect controller for a sequential Booth multiplier
// Serialises operand pairs into the multiplier and queues tagged results in a small FIFO.
module booth_mul_sequencer #(
    parameter int WIDTH     = 8,
    parameter int TAG_W     = 4,
    parameter int RES_DEPTH = 4,
    parameter int TIMEOUT   = 40
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 mul_reset,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic [2*WIDTH-1:0]   mul_p,
    input  logic                 mul_rdy,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err,
    output logic                 busy
);
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CNT_W = $clog2(RES_DEPTH + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int EW    = TAG_W + 2 * WIDTH + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [EW-1:0]    mem_q [RES_DEPTH];
    logic [EW-1:0]    mem_d [RES_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic [EW-1:0]    push_data;

    assign in_ready  = (state_q == S_IDLE) && (count_q < CNT_W'(RES_DEPTH));
    assign mul_reset = reset || (state_q == S_LOAD);
    assign mul_a     = a_q;
    assign mul_b     = b_q;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (count_q != '0);
    assign pop       = out_valid && out_ready;
    assign {out_tag, out_p, out_err} = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        tag_d     = tag_q;
        to_d      = to_q;
        push      = 1'b0;
        push_data = '0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    tag_d   = in_tag;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                to_d    = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                // A done flag in the final timeout cycle still counts as success.
                if (mul_rdy) begin
                    push      = 1'b1;
                    push_data = {tag_q, mul_p, 1'b0};
                    state_d   = S_IDLE;
                end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                    push      = 1'b1;
                    push_data = {tag_q, {(2*WIDTH){1'b0}}, 1'b1};
                    state_d   = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop && (count_q < CNT_W'(RES_DEPTH))) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            tag_q    <= '0;
            to_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < RES_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            tag_q    <= tag_d;
            to_q     <= to_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule
